// File: rtl/pe_injector.sv
// PE injector: queues packets from a processing element and presents them, in order, to a router input port.
// Latency: 1 cycle from a push into an empty queue to rt_valid; no combinational path from pe_* to rt_*.
// Backpressure: pe_ready drops when all FIFO_DEPTH entries are occupied; the head is held stable while rt_ready is low.
// Optional feature: define INJECT_STATS_EN to add the 16-bit tx_count delivered-packet counter port.

package global_params;
    localparam int MESH_SIDE  = 4;
    localparam int DATA_WIDTH = 32;
endpackage

module pe_injector #(
    parameter int MESH_SIDE  = global_params::MESH_SIDE,
    parameter int DATA_WIDTH = global_params::DATA_WIDTH,
    parameter int LOCAL_X    = 0,
    parameter int LOCAL_Y    = 0,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = (MESH_SIDE > 1) ? $clog2(MESH_SIDE) : 1,
    localparam int PW        = $clog2(FIFO_DEPTH),
    localparam int NW        = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pe_valid,
    output logic                  pe_ready,
    input  logic [CW-1:0]         pe_dest_x,
    input  logic [CW-1:0]         pe_dest_y,
    input  logic [DATA_WIDTH-1:0] pe_data,
    output logic                  rt_s_delta_x,
    output logic                  rt_s_delta_y,
    output logic [CW-1:0]         rt_dest_x,
    output logic [CW-1:0]         rt_dest_y,
    output logic [DATA_WIDTH-1:0] rt_data,
    output logic                  rt_valid,
    input  logic                  rt_ready
`ifdef INJECT_STATS_EN
    ,
    output logic [15:0]           tx_count
`endif
);

    // One queued packet: routing sign bits are resolved at enqueue time so the
    // router sees them straight from a register.
    typedef struct packed {
        logic                  s_delta_x;
        logic                  s_delta_y;
        logic [CW-1:0]         dest_x;
        logic [CW-1:0]         dest_y;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    localparam logic [CW-1:0] LOCAL_X_C = CW'(LOCAL_X);
    localparam logic [CW-1:0] LOCAL_Y_C = CW'(LOCAL_Y);
    localparam logic [NW-1:0] DEPTH_C   = NW'(FIFO_DEPTH);

    entry_t        mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [NW-1:0] count;
    entry_t        wr_entry;
    entry_t        head;
    logic          push;
    logic          pop;

    // Handshake qualification; flags depend only on registered occupancy.
    always_comb begin
        pe_ready = (count != DEPTH_C);
        rt_valid = (count != '0);
        push     = pe_valid && pe_ready && !rst;
        pop      = rt_valid && rt_ready && !rst;
    end

    // Build the entry to enqueue; the sign bits flag a destination below the local coordinate.
    always_comb begin
        wr_entry.s_delta_x = (pe_dest_x < LOCAL_X_C);
        wr_entry.s_delta_y = (pe_dest_y < LOCAL_Y_C);
        wr_entry.dest_x    = pe_dest_x;
        wr_entry.dest_y    = pe_dest_y;
        wr_entry.data      = pe_data;
    end

    // Entry storage; not reset because outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers and occupancy; power-of-two depth makes pointer wrap implicit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Head entry drives the router; forced to zero when nothing is queued so reset state reads clean.
    always_comb begin
        head         = mem[rd_ptr];
        rt_s_delta_x = rt_valid ? head.s_delta_x : 1'b0;
        rt_s_delta_y = rt_valid ? head.s_delta_y : 1'b0;
        rt_dest_x    = rt_valid ? head.dest_x    : '0;
        rt_dest_y    = rt_valid ? head.dest_y    : '0;
        rt_data      = rt_valid ? head.data      : '0;
    end

`ifdef INJECT_STATS_EN
    // Delivered-packet counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_count <= '0;
        end else if (pop) begin
            tx_count <= tx_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_injector.sv
// Testbench for pe_injector: directed scenarios plus a randomized run against a queue model.
// Latency: model advances one clock per tick; outputs sampled on the falling edge.
// Backpressure: model accepts only when its queue holds fewer than DEPTH packets.
module tb_pe_injector;

    localparam int MS    = 4;
    localparam int DW    = 16;
    localparam int LX    = 1;
    localparam int LY    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 2;

    typedef struct {
        logic [CW-1:0] dx;
        logic [CW-1:0] dy;
        logic [DW-1:0] data;
    } pkt_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          pe_valid;
    logic          pe_ready;
    logic [CW-1:0] pe_dest_x;
    logic [CW-1:0] pe_dest_y;
    logic [DW-1:0] pe_data;
    logic          rt_s_delta_x;
    logic          rt_s_delta_y;
    logic [CW-1:0] rt_dest_x;
    logic [CW-1:0] rt_dest_y;
    logic [DW-1:0] rt_data;
    logic          rt_valid;
    logic          rt_ready;
`ifdef INJECT_STATS_EN
    logic [15:0]   tx_count;
`endif

    pkt_t mq[$];
    pkt_t done_q[$];
    int   tx_exp;
    int   n_checks;
    int   n_fail;

    pe_injector #(
        .MESH_SIDE (MS),
        .DATA_WIDTH(DW),
        .LOCAL_X   (LX),
        .LOCAL_Y   (LY),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pe_valid    (pe_valid),
        .pe_ready    (pe_ready),
        .pe_dest_x   (pe_dest_x),
        .pe_dest_y   (pe_dest_y),
        .pe_data     (pe_data),
        .rt_s_delta_x(rt_s_delta_x),
        .rt_s_delta_y(rt_s_delta_y),
        .rt_dest_x   (rt_dest_x),
        .rt_dest_y   (rt_dest_y),
        .rt_data     (rt_data),
        .rt_valid    (rt_valid),
        .rt_ready    (rt_ready)
`ifdef INJECT_STATS_EN
        ,
        .tx_count    (tx_count)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock edge and apply the same handshakes to the queue model.
    task automatic tick();
        bit   do_push;
        bit   do_pop;
        pkt_t p;
        do_push = pe_valid && (mq.size() < DEPTH) && !rst;
        do_pop  = rt_ready && (mq.size() > 0) && !rst;
        p.dx    = pe_dest_x;
        p.dy    = pe_dest_y;
        p.data  = pe_data;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            tx_exp = 0;
        end else begin
            if (do_pop) begin
                done_q.push_back(mq.pop_front());
                tx_exp++;
            end
            if (do_push) begin
                mq.push_back(p);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        pe_valid  = 1'b1;
        rt_ready  = 1'b1;
        pe_dest_x = 2'd3;
        pe_dest_y = 2'd3;
        pe_data   = 16'hBEEF;
        tick();
        tick();
        rst      = 1'b0;
        pe_valid = 1'b0;
        rt_ready = 1'b0;
        n_checks++;
        if (pe_ready !== 1'b1 || rt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got pe_ready=%b rt_valid=%b, want 1 0", pe_ready, rt_valid);
        end
        n_checks++;
        if ({rt_s_delta_x, rt_s_delta_y, rt_dest_x, rt_dest_y, rt_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: got sx=%b sy=%b x=%0d y=%0d data=%h, want all 0",
                     rt_s_delta_x, rt_s_delta_y, rt_dest_x, rt_dest_y, rt_data);
        end
`ifdef INJECT_STATS_EN
        n_checks++;
        if (tx_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_tx_count: got %0d, want 0", tx_count);
        end
`endif
    endtask

    task automatic test_sign_bits();
        pe_valid  = 1'b1;
        rt_ready  = 1'b1;
        pe_dest_x = 2'd0;
        pe_dest_y = 2'd3;
        pe_data   = 16'h1234;
        tick();
        pe_valid = 1'b0;
        n_checks++;
        if ({rt_valid, rt_s_delta_x, rt_s_delta_y, rt_dest_x, rt_dest_y, rt_data} !==
            {1'b1, 1'b1, 1'b0, 2'd0, 2'd3, 16'h1234}) begin
            n_fail++;
            $display("FAIL sign_bits: got v=%b sx=%b sy=%b x=%0d y=%0d data=%h, want v=1 sx=1 sy=0 x=0 y=3 data=1234",
                     rt_valid, rt_s_delta_x, rt_s_delta_y, rt_dest_x, rt_dest_y, rt_data);
        end
        tick();
        n_checks++;
        if (rt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sign_bits_drain: got rt_valid=%b, want 0", rt_valid);
        end
    endtask

    task automatic test_self_address();
        pe_valid  = 1'b1;
        rt_ready  = 1'b0;
        pe_dest_x = 2'd1;
        pe_dest_y = 2'd2;
        pe_data   = 16'h5A5A;
        tick();
        pe_valid = 1'b0;
        n_checks++;
        if ({rt_valid, rt_s_delta_x, rt_s_delta_y, rt_dest_x, rt_dest_y, rt_data} !==
            {1'b1, 1'b0, 1'b0, 2'd1, 2'd2, 16'h5A5A}) begin
            n_fail++;
            $display("FAIL self_address: got v=%b sx=%b sy=%b x=%0d y=%0d data=%h, want v=1 sx=0 sy=0 x=1 y=2 data=5a5a",
                     rt_valid, rt_s_delta_x, rt_s_delta_y, rt_dest_x, rt_dest_y, rt_data);
        end
        rt_ready = 1'b1;
        tick();
        rt_ready = 1'b0;
    endtask

    task automatic test_backpressure_release();
        rt_ready  = 1'b0;
        pe_valid  = 1'b1;
        pe_dest_x = 2'd2;
        pe_dest_y = 2'd1;
        for (int i = 0; i < 4; i++) begin
            pe_data = 16'hD000 + 16'(i);
            tick();
        end
        pe_data = 16'hD004;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (pe_ready !== 1'b0 || rt_valid !== 1'b1 || rt_data !== 16'hD000) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got pe_ready=%b rt_valid=%b rt_data=%h, want 0 1 d000",
                         i, pe_ready, rt_valid, rt_data);
            end
            tick();
        end
        rt_ready = 1'b1;
        #1;
        n_checks++;
        if (pe_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_no_comb_path: got pe_ready=%b, want 0", pe_ready);
        end
        tick();
        rt_ready = 1'b0;
        n_checks++;
        if (pe_ready !== 1'b1 || rt_data !== 16'hD001) begin
            n_fail++;
            $display("FAIL full_release: got pe_ready=%b rt_data=%h, want 1 d001", pe_ready, rt_data);
        end
        tick();
        pe_valid = 1'b0;
        n_checks++;
        if (pe_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL refill_full: got pe_ready=%b, want 0", pe_ready);
        end
        rt_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (rt_valid !== 1'b1 || rt_data !== 16'hD000 + 16'(i)) begin
                n_fail++;
                $display("FAIL release_order[%0d]: got rt_valid=%b rt_data=%h, want 1 %h",
                         i, rt_valid, rt_data, 16'hD000 + 16'(i));
            end
            tick();
        end
        n_checks++;
        if (rt_valid !== 1'b0 || pe_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_empty: got rt_valid=%b pe_ready=%b, want 0 1", rt_valid, pe_ready);
        end
        rt_ready = 1'b0;
    endtask

    task automatic test_streaming();
        pe_valid  = 1'b1;
        rt_ready  = 1'b1;
        pe_dest_x = 2'd3;
        pe_dest_y = 2'd0;
        for (int i = 0; i < 10; i++) begin
            pe_data = 16'(i);
            tick();
            n_checks++;
            if (rt_valid !== 1'b1 || pe_ready !== 1'b1 || rt_data !== 16'(i)) begin
                n_fail++;
                $display("FAIL streaming[%0d]: got rt_valid=%b pe_ready=%b rt_data=%0d, want 1 1 %0d",
                         i, rt_valid, pe_ready, rt_data, i);
            end
        end
        pe_valid = 1'b0;
        tick();
        rt_ready = 1'b0;
        n_checks++;
        if (rt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL streaming_drain: got rt_valid=%b, want 0", rt_valid);
        end
    endtask

    task automatic test_reset_mid();
        rt_ready = 1'b0;
        pe_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pe_dest_x = 2'(i);
            pe_dest_y = 2'(i + 1);
            pe_data   = 16'hC000 + 16'(i);
            tick();
        end
        n_checks++;
        if (rt_valid !== 1'b1 || rt_data !== 16'hC000) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got rt_valid=%b rt_data=%h, want 1 c000", rt_valid, rt_data);
        end
        rst      = 1'b1;
        rt_ready = 1'b1;
        tick();
        rst      = 1'b0;
        pe_valid = 1'b0;
        rt_ready = 1'b0;
        n_checks++;
        if (rt_valid !== 1'b0 || pe_ready !== 1'b1 || rt_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got rt_valid=%b pe_ready=%b rt_data=%h, want 0 1 0",
                     rt_valid, pe_ready, rt_data);
        end
`ifdef INJECT_STATS_EN
        n_checks++;
        if (tx_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_tx_count: got %0d, want 0", tx_count);
        end
`endif
        tick();
        n_checks++;
        if (rt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cycle_push: got rt_valid=%b, want 0", rt_valid);
        end
    endtask

    task automatic test_random();
        logic [21:0] got;
        logic [21:0] exp;
        int          pushed;
        int          popped;
        pushed = 0;
        popped = done_q.size();
        for (int c = 0; c < 600; c++) begin
            // Phases bias toward filling, draining, then mixed traffic.
            pe_valid  = (c < 200) ? ($urandom_range(0, 3) != 0) :
                        (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            rt_ready  = (c < 200) ? ($urandom_range(0, 3) == 0) :
                        (c < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            pe_dest_x = 2'($urandom_range(0, MS - 1));
            pe_dest_y = 2'($urandom_range(0, MS - 1));
            pe_data   = 16'($urandom);
            if (pe_valid && mq.size() < DEPTH) pushed++;
            n_checks++;
            if (pe_ready !== (mq.size() != DEPTH) || rt_valid !== (mq.size() != 0)) begin
                n_fail++;
                $display("FAIL random_flags[%0d]: got pe_ready=%b rt_valid=%b, want %b %b (occupancy %0d)",
                         c, pe_ready, rt_valid, mq.size() != DEPTH, mq.size() != 0, mq.size());
            end
            if (mq.size() != 0) begin
                got = {rt_s_delta_x, rt_s_delta_y, rt_dest_x, rt_dest_y, rt_data};
                exp = {int'(mq[0].dx) < LX, int'(mq[0].dy) < LY, mq[0].dx, mq[0].dy, mq[0].data};
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL random_head[%0d]: got %h, want %h", c, got, exp);
                end
            end
`ifdef INJECT_STATS_EN
            n_checks++;
            if (tx_count !== 16'(tx_exp)) begin
                n_fail++;
                $display("FAIL random_tx_count[%0d]: got %0d, want %0d", c, tx_count, 16'(tx_exp));
            end
`endif
            tick();
        end
        n_checks++;
        if (pushed != (done_q.size() - popped) + mq.size()) begin
            n_fail++;
            $display("FAIL random_conservation: got delivered+queued=%0d, want pushed=%0d",
                     (done_q.size() - popped) + mq.size(), pushed);
        end
        pe_valid = 1'b0;
        rt_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        tx_exp    = 0;
        rst       = 1'b1;
        pe_valid  = 1'b0;
        rt_ready  = 1'b0;
        pe_dest_x = '0;
        pe_dest_y = '0;
        pe_data   = '0;
        @(negedge clk);
        test_reset();
        test_sign_bits();
        test_self_address();
        test_backpressure_release();
        test_streaming();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_injector.md
PE_INJECTOR -- requirements
Module: pe_injector

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter MESH_SIDE SHALL default to global_params::MESH_SIDE and give the mesh side length.
REQ-003 Parameter DATA_WIDTH SHALL default to global_params::DATA_WIDTH and give the payload width.
REQ-004 Parameter LOCAL_X SHALL default to 0 and give the x coordinate of the attached router.
REQ-005 Parameter LOCAL_Y SHALL default to 0 and give the y coordinate of the attached router.
REQ-006 Parameter FIFO_DEPTH SHALL default to 4 and give the queue depth; it SHALL be a power of two and at least 2.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 pe_valid  in  1  the PE offers a packet.
REQ-010 pe_ready  out  1  the injector can accept a packet.
REQ-011 pe_dest_x, pe_dest_y  in  $clog2(MESH_SIDE) each  destination coordinates.
REQ-012 pe_data  in  DATA_WIDTH  payload.
REQ-013 rt_s_delta_x, rt_s_delta_y  out  1 each  direction sign bits to the router input port.
REQ-014 rt_dest_x, rt_dest_y  out  $clog2(MESH_SIDE) each  destination to the router.
REQ-015 rt_data  out  DATA_WIDTH  payload to the router.
REQ-016 rt_valid  out  1  a packet is presented to the router.
REQ-017 rt_ready  in  1  the router accepts the packet.
REQ-018 tx_count  out  16  count of delivered packets; present only when INJECT_STATS_EN is defined.

Function
REQ-019 The injector SHALL be a FIFO_DEPTH-entry circular FIFO with read and write pointers and an occupancy count of $clog2(FIFO_DEPTH)+1 bits.
REQ-020 pe_ready SHALL equal (count != FIFO_DEPTH) and SHALL NOT depend combinationally on rt_ready.
REQ-021 A push SHALL occur when pe_valid and pe_ready are both high.
REQ-022 A pop SHALL occur when rt_valid and rt_ready are both high.
REQ-023 rt_valid SHALL equal (count != 0).
REQ-024 The rt_* fields SHALL come from the FIFO head entry.
REQ-025 On push, the entry SHALL store s_delta_x = (pe_dest_x < LOCAL_X) and s_delta_y = (pe_dest_y < LOCAL_Y), using an unsigned compare at coordinate width.
REQ-026 On push, the entry SHALL also store pe_dest_x, pe_dest_y and pe_data unchanged.
REQ-027 A self-addressed packet (destination equal to the local coordinate) SHALL be enqueued normally with both sign bits 0.
REQ-028 Latency from a push into an empty FIFO to rt_valid going high SHALL be 1 cycle.
REQ-029 There SHALL be no combinational bypass from pe_* to rt_*.
REQ-030 While rt_valid is high and rt_ready is low, all rt_* outputs SHALL hold stable.
REQ-031 A simultaneous push and pop SHALL leave count unchanged and advance both pointers; this can only occur when the FIFO is not full.
REQ-032 When the FIFO is full, pe_ready SHALL be 0 and a pop SHALL raise pe_ready on the following cycle.
REQ-033 When the FIFO is empty, rt_ready SHALL be ignored and no pop SHALL occur.
REQ-034 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-035 Packets SHALL leave in strict arrival order with no loss or duplication.

Reset
REQ-036 While rst is high at a clock edge, pointers, count, rt_valid and tx_count SHALL clear to 0.
REQ-037 After reset, pe_ready SHALL be 1.
REQ-038 After reset, rt_s_delta_x, rt_s_delta_y, rt_dest_x, rt_dest_y and rt_data SHALL read 0.
REQ-039 A reset asserted mid-operation SHALL discard all queued packets.
REQ-040 A handshake in the reset cycle SHALL have no effect.

Configuration
REQ-041 When INJECT_STATS_EN is defined, tx_count SHALL increment by 1 on every pop.
REQ-042 tx_count SHALL wrap from 16'hFFFF to 0.
REQ-043 When INJECT_STATS_EN is not defined, the tx_count port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification (MESH_SIDE=4, LOCAL_X=1, LOCAL_Y=2, FIFO_DEPTH=4)
REQ-044 Sign bits: push dest (0,3), rt_ready=1 -> next cycle rt_valid=1, s_delta_x=1, s_delta_y=0, dest=(0,3).
REQ-045 Backpressure: rt_ready=0, push 5 packets D0..D4 back-to-back -> pe_ready=0 after the 4th push, D4 held at the PE, rt_data=D0 stable.
REQ-046 Full release: from the full state, raise rt_ready for 1 cycle -> D0 popped, pe_ready=1 the next cycle, D4 accepted, order D1..D4 preserved.
REQ-047 Streaming: pe_valid=1 and rt_ready=1 for 10 cycles with a data ramp 0..9 -> count stays at 1, output ramp 0..9 delayed 1 cycle.
REQ-048 Reset mid-operation: 3 packets queued, then rst for 1 cycle -> rt_valid=0, pe_ready=1, and tx_count=0 with INJECT_STATS_EN defined.
REQ-049 Self-address: push dest (1,2) -> delivered with s_delta_x=0 and s_delta_y=0.
